// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolution logic.
package branch_pkg;

  // Branch condition codes (funct3 of B-type instructions)
  localparam logic [2:0] FunctBeq  = 3'b000;
  localparam logic [2:0] FunctBne  = 3'b001;
  localparam logic [2:0] FunctBlt  = 3'b100;
  localparam logic [2:0] FunctBge  = 3'b101;
  localparam logic [2:0] FunctBltu = 3'b110;
  localparam logic [2:0] FunctBgeu = 3'b111;

  localparam int unsigned DefaultFlushCycles = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StSquash
  } bru_state_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation: funct3 and operands to taken/illegal.
module branch_compare
  import branch_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [Width-1:0] rs1_i,
  input  logic [Width-1:0] rs2_i,
  output logic             taken_o,
  output logic             illegal_o
);

  // Decode the condition; reserved codes resolve as not taken and flag illegal
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      FunctBeq:  taken_o = (rs1_i == rs2_i);
      FunctBne:  taken_o = (rs1_i != rs2_i);
      FunctBlt:  taken_o = ($signed(rs1_i) < $signed(rs2_i));
      FunctBge:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      FunctBltu: taken_o = (rs1_i < rs2_i);
      FunctBgeu: taken_o = (rs1_i >= rs2_i);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: mispredict redirect/flush handshake to fetch,
// predictor update pulses and saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = DefaultFlushCycles,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_branch_i,
  input  logic                  ex_is_jal_i,
  input  logic                  ex_is_jalr_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [ADDR_WIDTH-1:0] ex_pc_i,
  input  logic [ADDR_WIDTH-1:0] ex_imm_i,
  input  logic [ADDR_WIDTH-1:0] ex_rs1_i,
  input  logic [ADDR_WIDTH-1:0] ex_rs2_i,
  input  logic                  ex_pred_taken_i,
  input  logic                  fe_ready_i,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  flush_out_o,
  output logic                  stall_ex_o,
  output logic                  upd_valid_o,
  output logic                  upd_taken_o,
  output logic [ADDR_WIDTH-1:0] upd_pc_o,
  output logic [CNT_WIDTH-1:0]  perf_branches_o,
  output logic [CNT_WIDTH-1:0]  perf_mispredicts_o
);

  localparam int unsigned SqW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SqW-1:0] SqLast = SqW'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] JalrMask = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  bru_state_e            state_q;
  logic [SqW-1:0]        sq_cnt_q;
  logic                  redirect_valid_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;
  logic                  upd_valid_q;
  logic                  upd_taken_q;
  logic [ADDR_WIDTH-1:0] upd_pc_q;
  logic [CNT_WIDTH-1:0]  perf_br_q;
  logic [CNT_WIDTH-1:0]  perf_mp_q;

  logic                  cond_taken;
  logic                  cond_illegal;
  logic                  accept;
  logic                  is_jump;
  logic                  is_branch_ok;
  logic                  resolved;
  logic                  actual_taken;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] fall_through;

  branch_compare #(
    .Width (ADDR_WIDTH)
  ) u_compare (
    .funct3_i  (ex_funct3_i),
    .rs1_i     (ex_rs1_i),
    .rs2_i     (ex_rs2_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  // Resolution is only accepted while idle; stalled instructions are held upstream
  assign accept       = ex_valid_i && (state_q == StIdle);
  assign is_jump      = ex_is_jal_i || ex_is_jalr_i;
  assign is_branch_ok = ex_is_branch_i && !is_jump && !cond_illegal;
  assign resolved     = accept && (is_jump || is_branch_ok);
  assign actual_taken = is_jump ? 1'b1 : cond_taken;

  assign jalr_sum     = ex_rs1_i + ex_imm_i;
  assign target       = ex_is_jalr_i ? (jalr_sum & JalrMask) : (ex_pc_i + ex_imm_i);
  assign fall_through = ex_pc_i + ADDR_WIDTH'(4);

  // No indirect target comes from the predictor, so every JALR redirects
  always_comb begin
    mispredict = 1'b0;
    if (resolved) begin
      if (ex_is_jalr_i)     mispredict = 1'b1;
      else if (ex_is_jal_i) mispredict = !ex_pred_taken_i;
      else                  mispredict = (actual_taken != ex_pred_taken_i);
    end
  end

  // Redirect/squash FSM together with the registered redirect and update outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= StIdle;
      sq_cnt_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      upd_pc_q         <= '0;
    end else begin
      upd_valid_q <= accept && is_branch_ok;
      if (accept && is_branch_ok) begin
        upd_taken_q <= cond_taken;
        upd_pc_q    <= ex_pc_i;
      end
      case (state_q)
        StIdle: begin
          if (mispredict) begin
            state_q          <= StRedirect;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= actual_taken ? target : fall_through;
          end
        end
        StRedirect: begin
          if (fe_ready_i) begin
            state_q          <= StSquash;
            redirect_valid_q <= 1'b0;
            sq_cnt_q         <= '0;
          end
        end
        StSquash: begin
          if (sq_cnt_q == SqLast) state_q <= StIdle;
          else                    sq_cnt_q <= sq_cnt_q + SqW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (resolved && !(&perf_br_q))   perf_br_q <= perf_br_q + CNT_WIDTH'(1);
      if (mispredict && !(&perf_mp_q)) perf_mp_q <= perf_mp_q + CNT_WIDTH'(1);
    end
  end

  assign redirect_valid_o   = redirect_valid_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign flush_out_o        = (state_q != StIdle);
  assign stall_ex_o         = (state_q != StIdle);
  assign upd_valid_o        = upd_valid_q;
  assign upd_taken_o        = upd_taken_q;
  assign upd_pc_o           = upd_pc_q;
  assign perf_branches_o    = perf_br_q;
  assign perf_mispredicts_o = perf_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases then random traffic.
module tb_branch_resolve_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
  logic [2:0]    ex_funct3 = '0;
  logic [AW-1:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0, ex_rs2 = '0;
  logic          ex_pred_taken = 1'b0, fe_ready = 1'b0;

  logic          redirect_valid, flush_out, stall_ex, upd_valid, upd_taken;
  logic [AW-1:0] redirect_pc, upd_pc;
  logic [31:0]   perf_branches, perf_mispredicts;

  logic          s_redirect_valid, s_flush_out, s_stall_ex, s_upd_valid, s_upd_taken;
  logic [AW-1:0] s_redirect_pc, s_upd_pc;
  logic [3:0]    s_perf_branches, s_perf_mispredicts;

  branch_resolve_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jal_i(ex_is_jal), .ex_is_jalr_i(ex_is_jalr), .ex_funct3_i(ex_funct3),
    .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .ex_pred_taken_i(ex_pred_taken), .fe_ready_i(fe_ready),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .flush_out_o(flush_out),
    .stall_ex_o(stall_ex), .upd_valid_o(upd_valid), .upd_taken_o(upd_taken), .upd_pc_o(upd_pc),
    .perf_branches_o(perf_branches), .perf_mispredicts_o(perf_mispredicts)
  );

  // Narrow-counter instance sharing the stimulus, used for saturation
  branch_resolve_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(4)) dut_small (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jal_i(ex_is_jal), .ex_is_jalr_i(ex_is_jalr), .ex_funct3_i(ex_funct3),
    .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .ex_pred_taken_i(ex_pred_taken), .fe_ready_i(fe_ready),
    .redirect_valid_o(s_redirect_valid), .redirect_pc_o(s_redirect_pc),
    .flush_out_o(s_flush_out), .stall_ex_o(s_stall_ex), .upd_valid_o(s_upd_valid),
    .upd_taken_o(s_upd_taken), .upd_pc_o(s_upd_pc),
    .perf_branches_o(s_perf_branches), .perf_mispredicts_o(s_perf_mispredicts)
  );

  typedef struct {
    logic [AW-1:0] pc;
    bit            taken;
  } upd_t;

  upd_t          upd_q[$];
  logic [AW-1:0] rdr_q[$];

  int      total = 0;
  int      bad = 0;
  bit      running = 1'b0;
  bit      chk_reset = 1'b0;
  // Reference model: pending redirect, remaining flush cycles, event counts
  bit      m_pend = 1'b0;
  int      m_sq = 0;
  longint  m_br = 0;
  longint  m_mp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic bit cond(input logic [2:0] f3, input logic [AW-1:0] a, input logic [AW-1:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs and advance the model to the post-edge state
  task automatic step(input bit rst, input bit v, input bit br, input bit jal, input bit jalr,
                      input logic [2:0] f3, input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                      input logic [AW-1:0] a, input logic [AW-1:0] b, input bit pred,
                      input bit fe);
    bit            legal;
    bit            tk;
    bit            misp;
    logic [AW-1:0] tgt;
    logic [AW-1:0] ft;
    @(negedge clk);
    reset = rst; ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = a; ex_rs2 = b;
    ex_pred_taken = pred; fe_ready = fe;
    chk_reset = rst;
    if (rst) begin
      m_pend = 1'b0; m_sq = 0; m_br = 0; m_mp = 0;
      upd_q.delete();
      rdr_q.delete();
    end else if (!m_pend && m_sq == 0) begin
      if (v) begin
        legal = 1'b1;
        tk    = 1'b1;
        misp  = 1'b0;
        tgt   = jalr ? ((a + imm) & ~32'd1) : (pc + imm);
        ft    = pc + 32'd4;
        if (jalr) misp = 1'b1;
        else if (jal) misp = !pred;
        else if (br) begin
          legal = (f3 != 3'd2) && (f3 != 3'd3);
          tk    = legal && cond(f3, a, b);
          misp  = legal && (tk != pred);
          if (legal) upd_q.push_back('{pc: pc, taken: tk});
        end else legal = 1'b0;
        if (legal) m_br++;
        if (misp) begin
          m_mp++;
          m_pend = 1'b1;
          rdr_q.push_back(tk ? tgt : ft);
        end
      end
    end else if (m_pend) begin
      if (fe) begin
        m_pend = 1'b0;
        m_sq   = FC;
      end
    end else begin
      m_sq--;
    end
  endtask

  task automatic idle(input bit fe);
    step(0, 0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, fe);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_pend || m_sq > 0) && n < 50) begin
      idle(1);
      n++;
    end
    if (n >= 50) fail("drain_timeout", "DUT model never returned to idle");
  endtask

  // Monitor: per-cycle flag/counter checks and scoreboard pops on DUT events
  initial begin
    bit    prev_rv = 1'b0;
    upd_t  e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_pend});
        check("flush_out", {63'd0, flush_out}, {63'd0, (m_pend || m_sq > 0)});
        check("stall_ex", {63'd0, stall_ex}, {63'd0, (m_pend || m_sq > 0)});
        check("perf_branches", {32'd0, perf_branches}, m_br);
        check("perf_mispredicts", {32'd0, perf_mispredicts}, m_mp);
        check("perf_branches_sat", {60'd0, s_perf_branches}, (m_br > 15) ? 64'd15 : m_br);
        check("perf_mispredicts_sat", {60'd0, s_perf_mispredicts},
              (m_mp > 15) ? 64'd15 : m_mp);
        if (upd_valid) begin
          if (upd_q.size() == 0) fail("upd_spurious", "upd_valid with nothing expected");
          else begin
            e = upd_q.pop_front();
            check("upd_pc", {32'd0, upd_pc}, {32'd0, e.pc});
            check("upd_taken", {63'd0, upd_taken}, {63'd0, e.taken});
          end
        end
        if (upd_q.size() != 0) begin
          fail("upd_missing", "expected update pulse not seen");
          upd_q.delete();
        end
        if (redirect_valid) begin
          if (rdr_q.size() == 0) fail("redirect_spurious", "redirect with nothing expected");
          else check("redirect_pc", {32'd0, redirect_pc}, {32'd0, rdr_q[0]});
        end else if (prev_rv && rdr_q.size() > 0) begin
          void'(rdr_q.pop_front());
        end
        if (chk_reset) begin
          check("reset_redirect_pc", {32'd0, redirect_pc}, 64'd0);
          check("reset_upd_pc", {32'd0, upd_pc}, 64'd0);
          check("reset_upd_taken", {63'd0, upd_taken}, 64'd0);
          check("reset_upd_valid", {63'd0, upd_valid}, 64'd0);
        end
        prev_rv = redirect_valid;
      end
    end
  end

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    running = 1'b1;
    step(1, 0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 0);
    step(1, 0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 0);

    // BEQ correctly predicted taken
    step(0, 1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1, 0);
    idle(0);
    // BLT signed: -1 < 1 taken, predicted not taken
    step(0, 1, 1, 0, 0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0);
    drain();
    // BLTU same operands not taken, predicted taken; fetch stalls, EX keeps offering
    step(0, 1, 1, 0, 0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1, 0);
    repeat (3) step(0, 1, 1, 0, 0, 3'b000, 32'h500, 32'h8, 32'd1, 32'd1, 0, 0);
    drain();
    // JALR target has bit 0 cleared
    step(0, 1, 0, 0, 1, 3'b000, 32'h400, 32'h0, 32'h1003, 32'd0, 1, 0);
    drain();
    // Reserved condition code
    step(0, 1, 1, 0, 0, 3'b010, 32'h440, 32'h8, 32'd3, 32'd3, 1, 0);
    idle(0);
    // JAL mispredict, then reset while the redirect is pending
    step(0, 1, 0, 1, 0, 3'b000, 32'h600, 32'h10, 32'd0, 32'd0, 0, 0);
    idle(0);
    step(1, 0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 0);
    idle(0);
    // Fall-through wraps around the address space
    step(0, 1, 1, 0, 0, 3'b001, 32'hFFFF_FFFC, 32'h8, 32'd7, 32'd7, 1, 0);
    drain();

    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 7);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom();
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) a = a % 8;
      pc   = {$urandom()} & 32'hFFFF_FFFC;
      imm  = 32'($signed($urandom_range(0, 4095)) - 2048);
      step(0, kind != 7, kind < 5, kind == 5, kind == 6, f3, pc, imm, a, b,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end
    drain();
    repeat (3) idle(0);
    if (rdr_q.size() != 0) fail("redirect_leftover", "expected redirect never retired");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution block, the consumer end of the branch predictor's prediction/update interface. It evaluates conditional branches and jumps carrying the fetch-time prediction and computes the real target. On a mispredict it drives a redirect/flush handshake to fetch. For every resolved conditional branch it returns the outcome to the predictor as a one-cycle update pulse, and it keeps saturating branch/mispredict performance counters.

## Interface
- ADDR_WIDTH, 32, PC/target width
- FLUSH_CYCLES, 2, cycles flush_out stays high after fetch accepts a redirect (≥1)
- CNT_WIDTH, 32, performance counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a valid instruction this cycle
- ex_is_branch  in  1  conditional branch (B-type)
- ex_is_jal / ex_is_jalr  in  1 each  unconditional jump kinds
- ex_funct3  in  3  branch condition code
- ex_pc, ex_imm, ex_rs1, ex_rs2  in  ADDR_WIDTH each  PC, sign-extended immediate, operands
- ex_pred_taken  in  1  prediction carried down from fetch
- fe_ready  in  1  fetch accepts redirect this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  ADDR_WIDTH  corrected fetch address
- flush_out  out  1  squash IF/ID contents
- stall_ex  out  1  EX must hold its instruction
- upd_valid  out  1  predictor update strobe (branch_outcome)
- upd_taken  out  1  actual direction (branch_taken)
- upd_pc  out  ADDR_WIDTH  PC of resolved branch
- perf_branches, perf_mispredicts  out  CNT_WIDTH each  saturating counters

## Operation
- Conditions: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU; 010/011 illegal → not taken, no update, no counting.
- Target: branch/JAL = ex_pc + ex_imm; JALR = (ex_rs1 + ex_imm) & ~1. Fall-through = ex_pc + 4. All sums modulo 2^ADDR_WIDTH.
- actual_taken: condition result for branches, 1 for jumps.
- Mispredict: branch with actual_taken ≠ ex_pred_taken; JAL with ex_pred_taken=0; JALR always. The predictor supplies no indirect target, so JALR always redirects.
- redirect_pc = actual_taken ? target : fall-through.
- Predictor update only for legal conditional branches: upd_valid=1, upd_taken=actual_taken, upd_pc=ex_pc.
- perf_branches++ per legal branch/jump resolved; perf_mispredicts++ per mispredict; both hold at all-ones.
- FSM: IDLE → REDIRECT on an accepted mispredict. REDIRECT → SQUASH in the cycle fe_ready=1 is sampled. SQUASH counts FLUSH_CYCLES, then → IDLE.
- flush_out=1 in REDIRECT and SQUASH. stall_ex=1 whenever state≠IDLE.
- A resolution is accepted only in IDLE. If ex_valid=1 while stall_ex=1, the instruction is not resolved, updated or counted; upstream holds it.

## Timing
- Resolution is combinational in cycle N (ex_valid=1, IDLE). All outputs are registered and appear at N+1.
- upd_valid is a one-cycle pulse at N+1, including on mispredicts.
- redirect_valid rises at N+1 and holds with a stable redirect_pc until fe_ready=1. It drops the cycle after acceptance, when SQUASH begins.
- Acceptance in the first REDIRECT cycle gives a total bubble of 1 + FLUSH_CYCLES cycles after N+1.
- Correct prediction: no redirect/flush/stall; a new branch is accepted every cycle back-to-back.
- Reset (any state, including mid-REDIRECT): state=IDLE, squash counter=0. redirect_valid, flush_out, stall_ex, upd_valid, upd_taken = 0. redirect_pc, upd_pc, perf counters = 0. A pending redirect is discarded.

## Structure
- Package branch_pkg: funct3 localparams (BEQ…BGEU), FSM state type {IDLE, REDIRECT, SQUASH}, default FLUSH_CYCLES.
- Sub-module branch_compare: combinational funct3/rs1/rs2 → taken + illegal flag. The top level holds the FSM, target adders, counters and output registers.

## Test plan
- BEQ, rs1=rs2=5, pred_taken=1, pc=0x100, imm=0x20 → N+1: upd_valid=1, upd_taken=1, upd_pc=0x100; no redirect; perf_branches=1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 → taken mispredict: redirect_pc=pc+imm, flush_out=1, perf_mispredicts=1.
- BLTU with the same operands, pred_taken=1 → not taken: redirect_pc=pc+4. fe_ready held low 3 cycles → redirect_valid and stall_ex stay high and redirect_pc stays stable; after acceptance flush_out is high for exactly FLUSH_CYCLES more cycles.
- JALR, rs1=0x1003, imm=0 → redirect_pc=0x1002, upd_valid=0. Then funct3=010 → no update, no count, no redirect.
- Mispredict with a second ex_valid during stall → second instruction ignored until IDLE. reset asserted mid-REDIRECT → all outputs and counters 0 the next cycle.
- Counters preloaded near all-ones (CNT_WIDTH=4) → saturate at 15. pc=0xFFFFFFFC, not taken → redirect_pc=0x00000000.
